// File: rtl/serial_add_pkg.sv
// Shared types for the serial-adder scheduler: FSM states, default width, requester id.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CAPT  = 2'd3
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter. Round-robin when SERIAL_ADD_SCHED_RR_EN is defined,
// otherwise fixed priority with req_i[0] always winning.
module rr_arb2
  import serial_add_pkg::*;
(
`ifdef SERIAL_ADD_SCHED_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       take_i,
`endif
  input  logic [1:0] req_i,
  output logic       valid_c,
  output req_id_t    win_c
);

`ifdef SERIAL_ADD_SCHED_RR_EN
  // prio_q names the requester that wins a tie; it flips away from whoever was just served
  req_id_t prio_q;

  always_comb begin
    valid_c = |req_i;
    if (&req_i) win_c = prio_q;
    else        win_c = req_i[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  prio_q <= 1'b0;
    else if (take_i && valid_c)  prio_q <= ~win_c;
  end
`else
  always_comb begin
    valid_c = |req_i;
    win_c   = ~req_i[0];
  end
`endif

endmodule

// File: rtl/serial_add_sched.sv
// Schedules two requesters onto one external WIDTH-cycle serial adder.
// Arbitration policy is selected by SERIAL_ADD_SCHED_RR_EN (defined: round-robin, else fixed).
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result_o,
  output logic             sa_pload,
  output logic             sa_enable,
  output logic [WIDTH-1:0] sa_adata,
  output logic [WIDTH-1:0] sa_bdata,
  input  logic [WIDTH-1:0] sa_pout
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  req_id_t          grant_id_q, grant_id_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             pload_q, pload_d, enable_q, enable_d;
  logic [WIDTH-1:0] adata_q, adata_d, bdata_q, bdata_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             arb_valid_c;
  req_id_t          arb_win_c;

  rr_arb2 u_arb (
`ifdef SERIAL_ADD_SCHED_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .take_i  (state_q == ST_IDLE),
`endif
    .req_i   ({req1, req0}),
    .valid_c (arb_valid_c),
    .win_c   (arb_win_c)
  );

  // Strobes are computed for the state being entered so every output comes straight from a flop
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_id_d = grant_id_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    pload_d    = 1'b0;
    enable_d   = 1'b0;
    adata_d    = '0;
    bdata_d    = '0;
    result_d   = result_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          state_d    = ST_LOAD;
          grant_id_d = arb_win_c;
          pload_d    = 1'b1;
          gnt0_d     = (arb_win_c == 1'b0);
          gnt1_d     = (arb_win_c == 1'b1);
          adata_d    = arb_win_c ? a1 : a0;
          bdata_d    = arb_win_c ? b1 : b0;
        end
      end
      ST_LOAD: begin
        state_d  = ST_SHIFT;
        cnt_d    = '0;
        enable_d = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          enable_d = 1'b1;
        end
      end
      ST_CAPT: begin
        state_d  = ST_IDLE;
        result_d = sa_pout;
        done0_d  = (grant_id_q == 1'b0);
        done1_d  = (grant_id_q == 1'b1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      grant_id_q <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      pload_q    <= 1'b0;
      enable_q   <= 1'b0;
      adata_q    <= '0;
      bdata_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_id_q <= grant_id_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      pload_q    <= pload_d;
      enable_q   <= enable_d;
      adata_q    <= adata_d;
      bdata_q    <= bdata_d;
      result_q   <= result_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign sa_pload  = pload_q;
  assign sa_enable = enable_q;
  assign sa_adata  = adata_q;
  assign sa_bdata  = bdata_q;
  assign result_o  = result_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: an LSB-first serial adder model, a timeline model of the
// scheduler checked every cycle, and directed scenarios with hand-computed results.
module tb_serial_add_sched;

  localparam int unsigned W   = 8;
  localparam int          LAT = 11;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, done0, done1, sa_pload, sa_enable;
  logic [W-1:0] result_o, sa_adata, sa_bdata, sa_pout;

  int n_chk = 0, n_err = 0, cyc = 0, en_seen = 0, done_seen = 0;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result_o(result_o), .sa_pload(sa_pload), .sa_enable(sa_enable),
    .sa_adata(sa_adata), .sa_bdata(sa_bdata), .sa_pout(sa_pout)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // External serial adder: bit-serial, LSB first, sum shifted in from the top
  logic [W-1:0] sr_a, sr_b, sr_s;
  logic         sr_c;
  always @(posedge clk) begin
    if (sa_pload) begin
      sr_a <= sa_adata; sr_b <= sa_bdata; sr_s <= '0; sr_c <= 1'b0;
    end else if (sa_enable) begin
      sr_s <= {sr_a[0] ^ sr_b[0] ^ sr_c, sr_s[W-1:1]};
      sr_a <= sr_a >> 1;
      sr_b <= sr_b >> 1;
      sr_c <= (sr_a[0] & sr_b[0]) | (sr_c & (sr_a[0] ^ sr_b[0]));
    end
  end
  assign sa_pout = sr_s;

  // Scheduler model: one operation at a time, described by its acceptance cycle m_t
  bit           m_act = 1'b0;
  int           m_t = 0;
  logic         m_id = 1'b0, m_last = 1'b1;
  logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0, m_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0; m_res = '0; m_last = 1'b1;
    end else begin
      if (m_act && cyc >= m_t + LAT) begin
        m_res = m_sum; m_act = 1'b0;
      end
      if (!m_act && (req0 || req1)) begin
`ifdef SERIAL_ADD_SCHED_RR_EN
        m_id = (req0 && req1) ? ~m_last : req1;
`else
        m_id = ~req0;
`endif
        m_last = m_id;
        m_act  = 1'b1;
        m_t    = cyc;
        m_a    = m_id ? a1 : a0;
        m_b    = m_id ? b1 : b0;
        m_sum  = W'(m_a + m_b);
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  int           d;
  logic         e_g0, e_g1, e_d0, e_d1, e_pl, e_en;
  logic [W-1:0] e_a, e_b, e_res;

  always @(negedge clk) begin
    if (cyc > 0) begin
      d     = m_act ? cyc - m_t : -1;
      e_pl  = (d == 1);
      e_g0  = e_pl && !m_id;
      e_g1  = e_pl && m_id;
      e_en  = (d >= 2) && (d <= int'(W) + 1);
      e_d0  = (d == LAT) && !m_id;
      e_d1  = (d == LAT) && m_id;
      e_a   = e_pl ? m_a : '0;
      e_b   = e_pl ? m_b : '0;
      e_res = (m_act && d >= LAT) ? m_sum : m_res;
      if (!rst_n) begin
        {e_g0, e_g1, e_d0, e_d1, e_pl, e_en} = '0;
        e_a = '0; e_b = '0; e_res = '0;
      end
      chk("gnt0", 32'(gnt0), 32'(e_g0));
      chk("gnt1", 32'(gnt1), 32'(e_g1));
      chk("done0", 32'(done0), 32'(e_d0));
      chk("done1", 32'(done1), 32'(e_d1));
      chk("sa_pload", 32'(sa_pload), 32'(e_pl));
      chk("sa_enable", 32'(sa_enable), 32'(e_en));
      chk("sa_adata", 32'(sa_adata), 32'(e_a));
      chk("sa_bdata", 32'(sa_bdata), 32'(e_b));
      chk("result_o", 32'(result_o), 32'(e_res));
      chk("pload_enable_overlap", 32'(sa_pload & sa_enable), 32'd0);
      chk("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
      chk("done_overlap", 32'(done0 & done1), 32'd0);
      if (sa_enable) en_seen++;
      if (done0 || done1) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 any gnt, else any done
  task automatic wait_sig(input int which, input int budget, input string nm, output int at);
    logic hit;
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = gnt0;
        1:       hit = gnt1;
        2:       hit = done0;
        3:       hit = done1;
        4:       hit = gnt0 | gnt1;
        default: hit = done0 | done1;
      endcase
      if (hit === 1'b1) at = cyc;
    end
    n_chk++;
    if (at < 0) begin
      n_err++;
      $display("FAIL %s: actual timeout after %0d cycles required pulse", nm, budget);
    end
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string nm);
    int t, g, dn, e0;
    tick();
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
    t  = cyc;
    e0 = en_seen;
    wait_sig(id ? 1 : 0, 5, {nm, "_gnt"}, g);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    wait_sig(id ? 3 : 2, 20, {nm, "_done"}, dn);
    chk({nm, "_gnt_lat"}, 32'(g - t), 32'd1);
    chk({nm, "_done_lat"}, 32'(dn - t), 32'(LAT));
    chk({nm, "_result"}, 32'(result_o), 32'(exp));
    chk({nm, "_enable_cycles"}, 32'(en_seen - e0), 32'(W));
  endtask

  int       g, g1, dn, d0, d1, d2, d3, t, ds0;
  logic [2:0] order;

  initial begin
    repeat (3) tick();
    chk("reset_result", 32'(result_o), 32'd0);
    chk("reset_strobes", 32'({gnt0, gnt1, done0, done1, sa_pload, sa_enable}), 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 8'h35, 8'h1A, 8'h4F, "s1");
    run_op(1'b1, 8'hFF, 8'h01, 8'h00, "s2");

    // Simultaneous requests: req0 first, req1 in the cycle after done0
    tick();
    a0 = 8'h10; b0 = 8'h20; a1 = 8'h03; b1 = 8'h04;
    req0 = 1'b1; req1 = 1'b1;
    wait_sig(0, 5, "s3_gnt0", g);
    req0 = 1'b0;
    wait_sig(2, 20, "s3_done0", d0);
    chk("s3_result0", 32'(result_o), 32'h30);
    wait_sig(1, 5, "s3_gnt1", g1);
    req1 = 1'b0;
    chk("s3_gnt1_after_done0", 32'(g1 - d0), 32'd1);
    wait_sig(3, 20, "s3_done1", d1);
    chk("s3_result1", 32'(result_o), 32'h07);

    // Both held for three grants: alternates under round-robin, req0 only under fixed priority
    tick();
    a0 = 8'h21; b0 = 8'h12; a1 = 8'h40; b1 = 8'h0C;
    req0 = 1'b1; req1 = 1'b1;
    order = '0;
    for (int k = 0; k < 3; k++) begin
      wait_sig(4, 15, "s4_gnt", g);
      order[k] = gnt1;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_sig(5, 15, "s4_done", dn);
`ifdef SERIAL_ADD_SCHED_RR_EN
    chk("s4_grant_order", 32'(order), 32'b010);
`else
    chk("s4_grant_order", 32'(order), 32'b000);
`endif
    chk("s4_result", 32'(result_o), 32'h33);

    // Reset during the 4th shift cycle drops the operation
    tick();
    a0 = 8'h55; b0 = 8'h11; req0 = 1'b1;
    wait_sig(0, 5, "s5_gnt", g);
    req0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    ds0 = done_seen;
    @(negedge clk);
    chk("s5_rst_enable", 32'(sa_enable), 32'd0);
    chk("s5_rst_result", 32'(result_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    a0 = 8'h01; b0 = 8'h01; req0 = 1'b1;
    t = cyc;
    wait_sig(0, 5, "s5_gnt_after_reset", g);
    req0 = 1'b0;
    wait_sig(2, 25, "s5_done", dn);
    chk("s5_gnt_lat", 32'(g - t), 32'd1);
    chk("s5_done_lat", 32'(dn - t), 32'(LAT));
    chk("s5_result", 32'(result_o), 32'h02);
    tick();
    chk("s5_done_count", 32'(done_seen - ds0), 32'd1);

    // req0 held: one completion every 11 cycles
    tick();
    a0 = 8'h7F; b0 = 8'h01; req0 = 1'b1;
    wait_sig(2, 20, "s6_done_a", d1);
    wait_sig(2, 20, "s6_done_b", d2);
    wait_sig(2, 20, "s6_done_c", d3);
    req0 = 1'b0;
    chk("s6_interval_1", 32'(d2 - d1), 32'(LAT));
    chk("s6_interval_2", 32'(d3 - d2), 32'(LAT));
    chk("s6_result", 32'(result_o), 32'h80);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
